// File: rtl/fetch_pkg.sv
// Shared fetch-path types: default widths, the {instr, pc} entry and the decode NOP.
// No logic here; the parameters and the struct keep fetch and decode consistent.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Decode injects this when it squashes an instruction; the fetch buffer never emits it.
    localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered head outputs, clear and occupancy count.
// Latency: push visible at head the next cycle; no backpressure, caller must not overflow.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             head_vld_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_dat_q, head_dat_d;

    always_comb begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_i);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_i);
        cnt_d      = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        head_vld_d = (cnt_d != '0);
        head_dat_d = head_dat_q;
        // The new head is the entry being written when it lands in the slot rd_ptr moves onto.
        if (cnt_d != '0) begin
            if (push_i && (rd_ptr_d == wr_ptr_q)) begin
                head_dat_d = push_dat_i;
            end else begin
                head_dat_d = mem_q[rd_ptr_d];
            end
        end
        if (clr_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            cnt_d      = '0;
            head_vld_d = 1'b0;
            head_dat_d = head_dat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            head_vld_q <= 1'b0;
            head_dat_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            head_vld_q <= head_vld_d;
            head_dat_q <= head_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clr_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_vld_o = head_vld_q;
    assign head_dat_o = head_dat_q;
    assign count_o    = cnt_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !clr_i && (cnt_q == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues one imem read per credit, tags returns with their PC, buffers for decode.
// Latency: issue in cycle N -> instr_valid in N+2; full credit stalls the PC via pc_hold.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_hold,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CR_W  = CNT_W + 1;

    logic                      pop;
    logic                      issue;
    logic                      push;
    logic [CR_W-1:0]           credit_used;
    logic [CNT_W-1:0]          fifo_cnt;
    logic [INSTR_W+ADDR_W-1:0] head_dat;
    logic                      inflight_q, inflight_d;
    logic [ADDR_W-1:0]         inflight_pc_q, inflight_pc_d;

    assign pop = instr_valid & instr_ready;

    // Slots already claimed once this cycle's pop retires; pop implies fifo_cnt >= 1.
    assign credit_used = {1'b0, fifo_cnt} + CR_W'(inflight_q) - CR_W'(pop);
    assign issue       = reset_n & ~flush & (credit_used < CR_W'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = pc_in;
    // Hold must drop during flush, otherwise the PC would refuse the redirect load.
    assign pc_hold   = ~reset_n | (~issue & ~flush);

    always_comb begin
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_in : inflight_pc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push = inflight_q & ~flush;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .clr_i      (flush),
        .push_i     (push),
        .push_dat_i ({imem_rdata, inflight_pc_q}),
        .pop_i      (pop),
        .head_vld_o (instr_valid),
        .head_dat_o (head_dat),
        .count_o    (fifo_cnt)
    );

    assign instr_out = head_dat[INSTR_W+ADDR_W-1:ADDR_W];
    assign instr_pc  = head_dat[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: PC + memory environment, queue-based reference model,
// directed scenarios with literal expectations followed by randomized ready/flush/step traffic.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [ADDR_W-1:0]  pc_in = '0;
    logic               pc_hold;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               flush = 1'b0;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_hold     (pc_hold),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    int n_cmp = 0;
    int n_err = 0;
    int mem_mode = 0;

    function automatic logic [INSTR_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        logic [7:0] h;
        if (mem_mode == 0) h = 8'hA5;
        else               h = (a * 8'd7) ^ 8'h5B;
        return {h, a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_fn(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered entries visible to decode, plus the one fetch in flight.
    fetch_entry_t      q[$];
    bit                pend = 1'b0;
    fetch_entry_t      pend_e;
    logic [ADDR_W-1:0] exp_pc = '0;
    logic [ADDR_W-1:0] step_sz = 8'd1;
    logic [ADDR_W-1:0] flush_tgt = '0;
    int                dut_occ = 0;
    int                dut_infl = 0;

    // One clock cycle: check at the falling edge, advance model and PC at the rising edge.
    task automatic step();
        bit                ev, pp, iss, dpp;
        fetch_entry_t      h;
        logic [ADDR_W-1:0] pc_nx;
        @(negedge clk);
        ev = (q.size() != 0);
        chk("instr_valid", instr_valid, ev);
        if (ev) begin
            chk("head_pc", instr_pc, q[0].pc);
            chk("head_instr", instr_out, q[0].instr);
        end
        pp  = ev && instr_ready;
        iss = !flush && ((q.size() + int'(pend) - int'(pp)) < DEPTH);
        chk("imem_en", imem_en, iss);
        chk("pc_hold", pc_hold, !iss && !flush);
        chk("imem_addr", imem_addr, pc_in);

        dpp = instr_valid && instr_ready;
        if (flush) dut_occ = 0;
        else       dut_occ = dut_occ + dut_infl - int'(dpp);
        dut_infl = (imem_en && !flush) ? 1 : 0;
        chk("occupancy_le_depth", (dut_occ + dut_infl) <= DEPTH, 1);

        if (pp) begin
            h = q.pop_front();
            chk("order_pc", h.pc, exp_pc);
            chk("order_instr", h.instr, mem_fn(exp_pc));
            exp_pc = exp_pc + step_sz;
        end
        if (flush) begin
            q.delete();
            pend   = 1'b0;
            exp_pc = flush_tgt;
        end else begin
            if (pend) q.push_back(pend_e);
            pend        = iss;
            pend_e.pc    = pc_in;
            pend_e.instr = mem_fn(pc_in);
        end
        pc_nx = flush ? flush_tgt : (pc_hold ? pc_in : pc_in + step_sz);
        @(posedge clk);
        #1;
        pc_in = pc_nx;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_imem_en", imem_en, 0);
        chk("rst_pc_hold", pc_hold, 1);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_pc", instr_pc, 0);
        q.delete();
        pend     = 1'b0;
        dut_occ  = 0;
        dut_infl = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_pc  = pc_in;
    endtask

    initial begin
        logic [ADDR_W-1:0] frz;
        logic [ADDR_W-1:0] rel_pc;
        bit                was_flush;

        #2;
        do_reset();

        // Streaming from PC 0 with decode always ready.
        instr_ready = 1'b1;
        step();
        chk("lat_first_valid", instr_valid, 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("stream_valid", instr_valid, 1);
            chk("stream_pc", instr_pc, k - 1);
            chk("stream_instr", instr_out, 32'hA500 + k - 1);
        end

        // Backpressure: head PC 6 stays, PC freezes at 8.
        instr_ready = 1'b0;
        repeat (3) step();
        chk("bp_pc_hold", pc_hold, 1);
        chk("bp_imem_en", imem_en, 0);
        chk("bp_head_pc", instr_pc, 8'h06);
        frz = pc_in;
        chk("bp_pc_frozen_val", frz, 8'h08);
        repeat (4) step();
        chk("bp_pc_still", pc_in, frz);
        instr_ready = 1'b1;
        repeat (6) step();

        // Flush with a full buffer, redirect to 0x40.
        instr_ready = 1'b0;
        repeat (3) step();
        flush     = 1'b1;
        flush_tgt = 8'h40;
        #1;
        chk("flush_pc_hold", pc_hold, 0);
        chk("flush_imem_en", imem_en, 0);
        step();
        flush = 1'b0;
        chk("post_flush_valid", instr_valid, 0);
        instr_ready = 1'b1;
        step();
        chk("post_flush_valid2", instr_valid, 0);
        step();
        chk("post_flush_first_valid", instr_valid, 1);
        chk("post_flush_first_pc", instr_pc, 8'h40);
        chk("post_flush_first_instr", instr_out, 16'hA540);
        repeat (4) step();

        // Wrap through 0xFF -> 0x00; the flush-cycle pop is kept.
        flush     = 1'b1;
        flush_tgt = 8'hFE;
        step();
        flush = 1'b0;
        step();
        step();
        chk("wrap_pc0", instr_pc, 8'hFE);
        chk("wrap_in0", instr_out, 16'hA5FE);
        step();
        chk("wrap_pc1", instr_pc, 8'hFF);
        chk("wrap_in1", instr_out, 16'hA5FF);
        step();
        chk("wrap_pc2", instr_pc, 8'h00);
        chk("wrap_in2", instr_out, 16'hA500);
        repeat (3) step();

        // Reset with the buffer full, then restart latency.
        instr_ready = 1'b0;
        repeat (3) step();
        do_reset();
        rel_pc      = pc_in;
        instr_ready = 1'b1;
        step();
        chk("rst_restart_valid0", instr_valid, 0);
        step();
        chk("rst_restart_valid1", instr_valid, 1);
        chk("rst_restart_pc", instr_pc, rel_pc);
        repeat (3) step();

        // Random ready, flushes and step sizes 1/3 with a different memory image.
        do_reset();
        mem_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            was_flush   = ($urandom_range(0, 39) == 0);
            flush       = was_flush;
            if (was_flush) flush_tgt = 8'($urandom_range(0, 255));
            if (i == 1500) begin
                flush = 1'b0;
                do_reset();
            end else begin
                step();
                flush = 1'b0;
                if (was_flush) step_sz = ($urandom_range(0, 1) != 0) ? 8'd1 : 8'd3;
            end
        end
        instr_ready = 1'b1;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
